// File: rtl/sort_pkg.sv
// Shared defaults and element/id types for the sorting-job arbiter.
package sort_pkg;
    localparam int SORT_DATA_W     = 8;
    localparam int SORT_NUM_REQ    = 4;
    localparam int SORT_PIPE_LAT   = 6;
    localparam int SORT_FIFO_DEPTH = 8;
    localparam int SORT_ELEMS      = 8;
    localparam int SORT_ID_W       = (SORT_NUM_REQ > 1) ? $clog2(SORT_NUM_REQ) : 1;

    typedef logic [SORT_ID_W-1:0]                sort_id_t;
    typedef logic [SORT_ELEMS*SORT_DATA_W-1:0]   sort_vec_t;
endpackage

// File: rtl/sort_rr_arb.sv
// Round-robin grant: search starts at i_ptr and wraps; at most one grant bit set.
module sort_rr_arb
    import sort_pkg::*;
#(
    parameter int NUM_REQ = SORT_NUM_REQ,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt
);
    logic w_found;
    int   w_idx;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = int'(i_ptr) + i;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (i_en && !w_found && (j == w_idx) && i_req[j]) begin
                    o_gnt[j] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/sort_arb.sv
// Credit-based round-robin front end for an external fixed-latency sorter, with an
// in-order response FIFO. Define SORT_ARB_CNT_EN to add the o_done_cnt pop counter.
module sort_arb
    import sort_pkg::*;
#(
    parameter int DATA_W     = SORT_DATA_W,
    parameter int NUM_REQ    = SORT_NUM_REQ,
    parameter int PIPE_LAT   = SORT_PIPE_LAT,
    parameter int FIFO_DEPTH = SORT_FIFO_DEPTH
)(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ*DATA_W*8-1:0] i_req_data,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic                        o_sort_valid,
    output logic [DATA_W*8-1:0]         o_sort_data,
    input  logic [DATA_W*8-1:0]         i_sort_data,
    output logic                        o_rsp_valid,
    output logic [DATA_W*8-1:0]         o_rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]  o_rsp_id,
    input  logic                        i_rsp_ready,
`ifdef SORT_ARB_CNT_EN
    output logic [15:0]                 o_done_cnt,
`endif
    output logic                        o_busy
);
    localparam int VEC_W = DATA_W * 8;
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic                r_en;
    logic [ID_W-1:0]     r_ptr;
    logic [CNT_W-1:0]    r_in_flight;
    logic [CNT_W-1:0]    r_fifo_cnt;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_gnt_id;
    logic [VEC_W-1:0]    w_gnt_data;
    logic                w_credit;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic [ID_W-1:0]     w_push_id;

    // Credit covers both the sorter pipeline and the FIFO, so the sorter never needs to stall.
    assign w_credit = ({1'b0, r_in_flight} + {1'b0, r_fifo_cnt}) < DEPTH_C;

    sort_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .i_req (i_req_valid),
        .i_ptr (r_ptr),
        .i_en  (r_en & w_credit),
        .o_gnt (w_gnt)
    );

    assign o_req_ready = w_gnt;
    assign w_accept    = |w_gnt;

    always_comb begin
        w_gnt_id   = '0;
        w_gnt_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_gnt[j]) begin
                w_gnt_id   = ID_W'(j);
                w_gnt_data = i_req_data[j*VEC_W +: VEC_W];
            end
        end
    end

    // Stage p0: issue register feeding the sorter
    logic               r_vld_p0;
    logic [VEC_W-1:0]   r_data_p0;
    logic [ID_W-1:0]    r_id_p0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en      <= 1'b0;
            r_ptr     <= '0;
            r_vld_p0  <= 1'b0;
            r_data_p0 <= '0;
            r_id_p0   <= '0;
        end else begin
            r_en     <= 1'b1;
            r_vld_p0 <= w_accept;
            if (w_accept) begin
                r_ptr     <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
                r_data_p0 <= w_gnt_data;
                r_id_p0   <= w_gnt_id;
            end
        end
    end

    assign o_sort_valid = r_vld_p0;
    assign o_sort_data  = r_data_p0;

    // Stage p1..: tag shift register aligned with the sorter latency
    logic [PIPE_LAT-1:0] r_tag_vld;
    logic [ID_W-1:0]     r_tag_id [PIPE_LAT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag_vld <= '0;
        end else begin
            r_tag_vld[0] <= r_vld_p0;
            for (int k = 1; k < PIPE_LAT; k++) r_tag_vld[k] <= r_tag_vld[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        r_tag_id[0] <= r_id_p0;
        for (int k = 1; k < PIPE_LAT; k++) r_tag_id[k] <= r_tag_id[k-1];
    end

    assign w_push    = r_tag_vld[PIPE_LAT-1];
    assign w_push_id = r_tag_id[PIPE_LAT-1];

    // Response FIFO: retire writes {sorted data, id}; head is shown combinationally
    logic [VEC_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]  r_mem_id   [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;

    assign o_rsp_valid = (r_fifo_cnt != '0);
    assign w_pop       = o_rsp_valid & i_rsp_ready;
    assign o_rsp_data  = o_rsp_valid ? r_mem_data[r_rd_ptr] : '0;
    assign o_rsp_id    = o_rsp_valid ? r_mem_id[r_rd_ptr]   : '0;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= i_sort_data;
            r_mem_id[r_wr_ptr]   <= w_push_id;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
            r_in_flight <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            case ({w_accept, w_push})
                2'b10:   r_in_flight <= r_in_flight + 1'b1;
                2'b01:   r_in_flight <= r_in_flight - 1'b1;
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    assign o_busy = (r_in_flight != '0) | (r_fifo_cnt != '0);

`ifdef SORT_ARB_CNT_EN
    logic [15:0] r_done_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_done_cnt <= '0;
        else if (w_pop) r_done_cnt <= r_done_cnt + 16'd1;
    end

    assign o_done_cnt = r_done_cnt;
`else
    // Default build carries no pop counter.
`endif
endmodule
